clock_divider_mc: RTL and testbench

- Multi-channel, runtime-programmable clock divider. It is the parametrised successor to the single fixed-ratio divider.
- Each of NUM_CH channels divides clk_in by an integer ratio that software can change at runtime. Each channel produces a registered near-50% divided level and a one-cycle period tick.
- Ratio changes are shadowed and applied only at a period boundary, so a change never produces a runt pulse.
- Sits between the system clock and peripheral timing logic (UART baud, PWM, LED scan). Consumers should use tick as a clock enable in preference to clk_out as a clock.

---
 rtl/clock_divider_pkg.sv | 14 +
 rtl/clock_divider_ch.sv | 68 ++++++
 rtl/clock_divider_mc.sv | 49 ++++
 tb/tb_clock_divider_mc.sv | 134 +++++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clock_divider_pkg;

  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 3;

  typedef logic [DIV_W-1:0] div_t;

  // High-phase length of a period: ceil(div/2), one bit wider than div so the maximum ratio cannot overflow.
  function automatic logic [32:0] hi_len(input logic [31:0] div);
    return ({1'b0, div} + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: period counter, active/shadow divisor and registered tick/level outputs.
module clock_divider_ch
  import clock_divider_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 3
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt, active_div, shadow_div;
  logic [CNT_W-1:0] cnt_nxt, div_nxt;
  logic [CNT_W:0]   last, hi;
  logic             run, start;

  // A period starts on the enabling edge, on sync, or on the natural wrap.
  always_comb begin
    last    = {1'b0, active_div} - (CNT_W+1)'(1);
    start   = !run || sync || ({1'b0, cnt} == last);
    div_nxt = (start && pending) ? shadow_div : active_div;
    cnt_nxt = start ? '0 : cnt + CNT_W'(1);
    hi      = (CNT_W+1)'(hi_len(32'(div_nxt)));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt        <= '0;
      active_div <= CNT_W'(DEF_DIV);
      shadow_div <= CNT_W'(DEF_DIV);
      pending    <= 1'b0;
      run        <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      if (!en) begin
        cnt     <= '0;
        run     <= 1'b0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        if (pending) begin
          active_div <= shadow_div;
          pending    <= 1'b0;
        end
      end else begin
        cnt        <= cnt_nxt;
        run        <= 1'b1;
        active_div <= div_nxt;
        tick       <= (cnt_nxt == '0);
        clk_out    <= ({1'b0, cnt_nxt} < hi);
        if (start) pending <= 1'b0;
      end
      // A write on a boundary edge misses that boundary and stays pending.
      if (wr) begin
        shadow_div <= wr_val;
        pending    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_divider_mc.sv
// Multi-channel runtime-programmable clock divider: write decode, error check and channel array.
module clock_divider_mc
  import clock_divider_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int CNT_W   = 16,
  parameter  int DEF_DIV = clock_divider_pkg::DEF_DIV,
  localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_pulse,
  input  logic              div_load,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic              load_err,
  output logic [NUM_CH-1:0] div_pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic load_ok;

  assign load_ok = div_load && (div_val != '0) && (32'(div_sel) < 32'(NUM_CH));

  always_ff @(posedge clk_in) begin
    if (rst) load_err <= 1'b0;
    else     load_err <= div_load && !load_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (ch_en[i]),
      .sync    (sync_pulse),
      .wr      (load_ok && (32'(div_sel) == 32'(i))),
      .wr_val  (div_val),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (div_pending[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_mc.sv
// Directed plus randomized bench for clock_divider_mc against a cycle-level behavioural model.
module tb_clock_divider_mc;

  localparam int NCH = 3;
  localparam int CW  = 4;
  localparam int DD  = 3;

  logic           clk_in = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] ch_en = '0;
  logic           sync_pulse = 1'b0;
  logic           div_load = 1'b0;
  logic [1:0]     div_sel = '0;
  logic [CW-1:0]  div_val = '0;
  logic           load_err;
  logic [NCH-1:0] div_pending, clk_out, tick;

  clock_divider_mc #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DD)) dut (
    .clk_in(clk_in), .rst(rst), .ch_en(ch_en), .sync_pulse(sync_pulse),
    .div_load(div_load), .div_sel(div_sel), .div_val(div_val),
    .load_err(load_err), .div_pending(div_pending), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  // Model: position within the current period, ratio in force, pending shadow.
  int m_pos[NCH], m_div[NCH], m_sh[NCH];
  bit m_pend[NCH], m_run[NCH], m_err;
  int vectors = 0, miscompares = 0;

  task automatic model(input logic [NCH-1:0] en, input bit sy, input bit ld,
                       input int sel, input int val, input bit r);
    bit ok;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        m_pos[c] = 0; m_div[c] = DD; m_sh[c] = DD; m_pend[c] = 0; m_run[c] = 0;
      end
      m_err = 0;
      return;
    end
    ok    = ld && val != 0 && sel < NCH;
    m_err = ld && !ok;
    for (int c = 0; c < NCH; c++) begin
      if (!en[c]) begin
        m_run[c] = 0; m_pos[c] = 0;
        if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
      end else begin
        if (!m_run[c] || sy || m_pos[c] == m_div[c] - 1) begin
          m_pos[c] = 0;
          if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
        end else m_pos[c]++;
        m_run[c] = 1;
      end
      if (ok && sel == c) begin m_sh[c] = val; m_pend[c] = 1; end
    end
  endtask

  task automatic check();
    logic [NCH-1:0] e_clk, e_tick, e_pend;
    for (int c = 0; c < NCH; c++) begin
      e_tick[c] = m_run[c] && m_pos[c] == 0;
      e_clk[c]  = m_run[c] && m_pos[c] < (m_div[c] + 1) / 2;
      e_pend[c] = m_pend[c];
    end
    vectors += 4;
    assert (clk_out === e_clk) else begin
      miscompares++; $error("FAIL clk_out obs=%b exp=%b t=%0t", clk_out, e_clk, $time);
    end
    assert (tick === e_tick) else begin
      miscompares++; $error("FAIL tick obs=%b exp=%b t=%0t", tick, e_tick, $time);
    end
    assert (div_pending === e_pend) else begin
      miscompares++; $error("FAIL div_pending obs=%b exp=%b t=%0t", div_pending, e_pend, $time);
    end
    assert (load_err === m_err) else begin
      miscompares++; $error("FAIL load_err obs=%b exp=%b t=%0t", load_err, m_err, $time);
    end
  endtask

  task automatic step(input logic [NCH-1:0] en, input bit sy = 0, input bit ld = 0,
                      input int sel = 0, input int val = 0, input bit r = 0);
    ch_en = en; sync_pulse = sy; div_load = ld;
    div_sel = 2'(sel); div_val = CW'(val); rst = r;
    @(posedge clk_in);
    model(en, sy, ld, sel, val, r);
    #1 check();
  endtask

  task automatic run(input logic [NCH-1:0] en, input int n);
    for (int i = 0; i < n; i++) step(en);
  endtask

  initial begin
    // Reset, then ch0 alone at the default ratio.
    step(3'b000, 0, 0, 0, 0, 1);
    step(3'b111, 1, 1, 1, 5, 1);
    run(3'b001, 10);
    // ch0 to div 4, then 6 written mid-period.
    step(3'b001, 0, 1, 0, 4);
    run(3'b001, 5);
    step(3'b001, 0, 1, 0, 6);
    run(3'b001, 14);
    // Rejected writes: zero divisor, out-of-range channel.
    step(3'b001, 0, 1, 0, 0);
    step(3'b001, 0, 1, 3, 9);
    run(3'b001, 7);
    // Alignment of ch0 div 5 and ch1 div 7.
    step(3'b001, 0, 1, 0, 5);
    step(3'b001, 0, 1, 1, 7);
    run(3'b011, 11);
    step(3'b011, 1);
    run(3'b011, 4);
    step(3'b011, 1);   // coincides with ch0 wrap
    run(3'b011, 16);
    // Edge ratios: ch2 div 1, ch1 div 15.
    step(3'b011, 0, 1, 2, 1);
    step(3'b011, 0, 1, 1, 15);
    run(3'b111, 35);
    // Reset mid-period with a write pending.
    step(3'b111, 0, 1, 0, 9);
    step(3'b111, 0, 0, 0, 0, 1);
    run(3'b001, 6);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] en;
      en = ($urandom_range(0, 19) == 0) ? NCH'($urandom) : 3'b111;
      step(en, $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 199) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
